idx_to_coord: RTL and testbench

IDX_TO_COORD -- requirements
Module: idx_to_coord

---
 rtl/oled_pkg.sv | 10 +
 rtl/idx_to_coord_if.sv | 30 +++
 rtl/div_by_const.sv | 30 +++
 rtl/idx_to_coord.sv | 109 ++++++++++
 tb/tb_idx_to_coord.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared OLED display geometry defaults used by the pixel-coordinate logic.
package oled_pkg;

  localparam int DEF_DISP_W   = 96;
  localparam int DEF_DISP_H   = 64;
  localparam int DEF_IDX_W    = 13;
  localparam int DEF_BOARD_X0 = 16;
  localparam int DEF_SQ       = 8;

endpackage

// File: rtl/idx_to_coord_if.sv
// Pixel-index request / coordinate result bundle for idx_to_coord.
interface idx_to_coord_if
  import oled_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
);

  // Valid-only stream, no ready: the sink accepts pix_index in every cycle where
  // in_valid=1, and out_valid marks a result exactly one cycle later.
  logic             in_valid;
  logic [IDX_W-1:0] pix_index;
  logic             out_valid;
  logic [IDX_W-1:0] x;
  logic [IDX_W-1:0] y;
  logic             on_board;
  logic [2:0]       sq_col;
  logic [2:0]       sq_row;
  logic             in_range;

  modport master (
    output in_valid, pix_index,
    input  out_valid, x, y, on_board, sq_col, sq_row, in_range
  );

  modport slave (
    input  in_valid, pix_index,
    output out_valid, x, y, on_board, sq_col, sq_row, in_range
  );

endinterface

// File: rtl/div_by_const.sv
// Combinational divide by a constant: quotient by reciprocal multiply and shift,
// remainder by back-multiplying the quotient.
module div_by_const
  import oled_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int DIVISOR = DEF_DISP_W
) (
  input  logic [IDX_W-1:0] dividend_i,
  output logic [IDX_W-1:0] quotient_o,
  output logic [IDX_W-1:0] remainder_o
);

  // With shift = IDX_W + ceil(log2 d) and mult = ceil(2^shift / d), the
  // truncated product equals floor(n/d) for every IDX_W-bit n.
  localparam int L  = $clog2(DIVISOR);
  localparam int S  = IDX_W + L;
  localparam int PW = 2 * IDX_W + 2;

  localparam logic [63:0]       M64   = ((64'd1 << S) + 64'(DIVISOR) - 64'd1) / 64'(DIVISOR);
  localparam logic [PW-1:0]     MULT  = PW'(M64);
  localparam logic [IDX_W-1:0]  DIV_C = IDX_W'(DIVISOR);

  logic [PW-1:0] product;

  assign product     = PW'(dividend_i) * MULT;
  assign quotient_o  = IDX_W'(product >> S);
  assign remainder_o = dividend_i - quotient_o * DIV_C;

endmodule

// File: rtl/idx_to_coord.sv
// Row-major pixel index to (x, y) and 8x8 board square, registered, latency 1.
// Optional IDX_TO_COORD_RANGE_CHECK_EN clamps indices beyond the display.
module idx_to_coord
  import oled_pkg::*;
#(
  parameter int DISP_W   = DEF_DISP_W,
  parameter int DISP_H   = DEF_DISP_H,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int BOARD_X0 = DEF_BOARD_X0,
  parameter int SQ       = DEF_SQ
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] pix_index,
  output logic             out_valid,
  output logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] y,
  output logic             on_board,
  output logic [2:0]       sq_col,
  output logic [2:0]       sq_row,
  output logic             in_range
);

  localparam logic [IDX_W-1:0] BX0 = IDX_W'(BOARD_X0);
  localparam logic [IDX_W-1:0] BX1 = IDX_W'(BOARD_X0 + 8 * SQ);
  localparam logic [IDX_W-1:0] BY1 = IDX_W'(8 * SQ);

  if (DISP_W * DISP_H > (1 << IDX_W)) begin : g_bad_geometry
    $error("idx_to_coord: display does not fit in the index width");
  end

  logic [IDX_W-1:0] x_raw, y_raw;
  logic [IDX_W-1:0] x_d, y_d, x_off;
  logic             on_board_d, in_range_d;
  logic [2:0]       sq_col_d, sq_row_d;

  logic             out_valid_q;
  logic [IDX_W-1:0] x_q, y_q;
  logic             on_board_q, in_range_q;
  logic [2:0]       sq_col_q, sq_row_q;

  div_by_const #(
    .IDX_W   (IDX_W),
    .DIVISOR (DISP_W)
  ) u_div (
    .dividend_i  (pix_index),
    .quotient_o  (y_raw),
    .remainder_o (x_raw)
  );

  // Square index from a board-relative offset via threshold compares; offset < 8*SQ.
  function automatic logic [2:0] sq_index(input logic [IDX_W-1:0] off);
    logic [2:0] r;
    r = '0;
    for (int k = 1; k < 8; k++) begin
      if (off >= IDX_W'(k * SQ)) r = 3'(k);
    end
    return r;
  endfunction

  always_comb begin
    x_d        = x_raw;
    y_d        = y_raw;
    in_range_d = 1'b1;
`ifdef IDX_TO_COORD_RANGE_CHECK_EN
    if ({1'b0, pix_index} >= (IDX_W + 1)'(DISP_W * DISP_H)) begin
      x_d        = IDX_W'(DISP_W - 1);
      y_d        = IDX_W'(DISP_H - 1);
      in_range_d = 1'b0;
    end
`endif
    on_board_d = in_range_d && (x_d >= BX0) && (x_d < BX1) && (y_d < BY1);
    x_off      = x_d - BX0;
    sq_col_d   = on_board_d ? sq_index(x_off) : 3'd0;
    sq_row_d   = on_board_d ? sq_index(y_d) : 3'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      on_board_q  <= 1'b0;
      sq_col_q    <= '0;
      sq_row_q    <= '0;
      in_range_q  <= 1'b1;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        x_q        <= x_d;
        y_q        <= y_d;
        on_board_q <= on_board_d;
        sq_col_q   <= sq_col_d;
        sq_row_q   <= sq_row_d;
        in_range_q <= in_range_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign on_board  = on_board_q;
  assign sq_col    = sq_col_q;
  assign sq_row    = sq_row_q;
  assign in_range  = in_range_q;

endmodule

// File: tb/tb_idx_to_coord.sv
// Self-checking bench for idx_to_coord: directed corner indices, reset, a full
// sweep of the display and random traffic against a mod/div reference model.
module tb_idx_to_coord;
  import oled_pkg::*;

  localparam int DISP_W   = DEF_DISP_W;
  localparam int DISP_H   = DEF_DISP_H;
  localparam int IDX_W    = DEF_IDX_W;
  localparam int BOARD_X0 = DEF_BOARD_X0;
  localparam int SQ       = DEF_SQ;
  localparam int RW       = 2 * IDX_W + 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  idx_to_coord_if #(.IDX_W(IDX_W)) bus ();

  idx_to_coord #(
    .DISP_W   (DISP_W),
    .DISP_H   (DISP_H),
    .IDX_W    (IDX_W),
    .BOARD_X0 (BOARD_X0),
    .SQ       (SQ)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .pix_index (bus.pix_index),
    .out_valid (bus.out_valid),
    .x         (bus.x),
    .y         (bus.y),
    .on_board  (bus.on_board),
    .sq_col    (bus.sq_col),
    .sq_row    (bus.sq_row),
    .in_range  (bus.in_range)
  );

  // scoreboard
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] held;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: plain mod/div and board geometry
  function automatic logic [RW-1:0] model(input int idx);
    int   mx, my, col, row;
    logic ob, rng;
    mx  = idx % DISP_W;
    my  = idx / DISP_W;
    rng = 1'b1;
`ifdef IDX_TO_COORD_RANGE_CHECK_EN
    if (idx >= DISP_W * DISP_H) begin
      mx  = DISP_W - 1;
      my  = DISP_H - 1;
      rng = 1'b0;
    end
`endif
    ob  = rng && (mx >= BOARD_X0) && (mx < BOARD_X0 + 8 * SQ) && (my < 8 * SQ);
    col = ob ? (mx - BOARD_X0) / SQ : 0;
    row = ob ? my / SQ : 0;
    return {IDX_W'(mx), IDX_W'(my), ob, 3'(col), 3'(row), rng};
  endfunction

  function automatic logic [RW-1:0] reset_vec();
    return {IDX_W'(0), IDX_W'(0), 1'b0, 3'd0, 3'd0, 1'b1};
  endfunction

  task automatic check_outputs(input string tag, input logic [RW-1:0] e);
    check({tag, "_x"},   bus.x,        e[RW-1 -: IDX_W]);
    check({tag, "_y"},   bus.y,        e[RW-IDX_W-1 -: IDX_W]);
    check({tag, "_ob"},  bus.on_board, e[7]);
    check({tag, "_col"}, bus.sq_col,   e[6:4]);
    check({tag, "_row"}, bus.sq_row,   e[3:1]);
    check({tag, "_rng"}, bus.in_range, e[0]);
  endtask

  // driver: present one cycle of input, then check the registered result
  task automatic step(input logic v, input logic [IDX_W-1:0] idx, input string tag);
    bus.in_valid  = v;
    bus.pix_index = idx;
    if (v) exp_q.push_back(model(int'(idx)));
    @(posedge clock);
    #1;
    check({tag, "_ov"}, bus.out_valid, v);
    if (v) held = exp_q.pop_front();
    check_outputs(tag, held);
  endtask

  task automatic apply_reset(input logic v, input logic [IDX_W-1:0] idx, input string tag);
    reset         = 1'b1;
    bus.in_valid  = v;
    bus.pix_index = idx;
    @(posedge clock);
    #1;
    exp_q.delete();
    held = reset_vec();
    check({tag, "_ov"}, bus.out_valid, 0);
    check_outputs(tag, held);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.pix_index = '0;
    held          = reset_vec();
    @(posedge clock);
    apply_reset(1'b0, '0, "rst");

    step(1'b1, 13'd0,    "i0");
    step(1'b1, 13'd95,   "i95");
    check("i95_x_lit", bus.x, 95);
    step(1'b1, 13'd96,   "i96");
    check("i96_y_lit", bus.y, 1);
    step(1'b1, 13'd6143, "i6143");
    check("i6143_x_lit", bus.x, 95);
    check("i6143_y_lit", bus.y, 63);

    step(1'b1, 13'd16,  "i16");
    check("i16_ob_lit", bus.on_board, 1);
    step(1'b1, 13'd884, "i884");
    check("i884_x_lit", bus.x, 20);
    check("i884_y_lit", bus.y, 9);
    check("i884_row_lit", bus.sq_row, 1);
    step(1'b1, 13'd951, "i951");
    check("i951_x_lit", bus.x, 87);
    check("i951_ob_lit", bus.on_board, 0);
    step(1'b1, 13'd79,  "i79");
    check("i79_col_lit", bus.sq_col, 7);
    step(1'b1, 13'd80,  "i80");
    check("i80_ob_lit", bus.on_board, 0);

    step(1'b0, 13'd1234, "hold");
    step(1'b0, 13'd17,   "hold2");

    step(1'b1, 13'd6144, "i6144");
`ifdef IDX_TO_COORD_RANGE_CHECK_EN
    check("i6144_rng_lit", bus.in_range, 0);
    check("i6144_x_lit", bus.x, 95);
    check("i6144_y_lit", bus.y, 63);
`else
    check("i6144_rng_lit", bus.in_range, 1);
    check("i6144_x_lit", bus.x, 0);
    check("i6144_y_lit", bus.y, 64);
`endif
    step(1'b1, 13'd8191, "i8191");

    apply_reset(1'b1, 13'd500, "rst_vs_valid");

    for (int i = 0; i < DISP_W * DISP_H; i++) begin
      step(1'b1, IDX_W'(i), "sweep");
    end

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, IDX_W'($urandom_range(0, (1 << IDX_W) - 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
